// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
//   Shared definitions for the HI/LO multiply/divide unit: bus widths, the
//   decode-stage aluop codes it reacts to, and a small magnitude helper.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam int unsigned ALUOP_W = 8;
    localparam int unsigned REG_W   = 32;

    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [REG_W-1:0] abs_if(input logic [REG_W-1:0] v,
                                                input logic             is_signed);
        return (is_signed && v[REG_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//   Pipeline-side bundle of the multiply/divide unit.
//   aluop_i/reg1_i/reg2_i : operation and operands from decode
//   flush_i               : abort in-flight operation
//   stallreq_o            : pipeline hold request
//   hi_o/lo_o             : registered HI/LO
//   busy_o                : unit not idle
//   master = pipeline side, slave = muldiv_unit side.
// -----------------------------------------------------------------------------
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic [ALUOP_W-1:0] aluop_i;
    logic [REG_W-1:0]   reg1_i;
    logic [REG_W-1:0]   reg2_i;
    logic               flush_i;
    logic               stallreq_o;
    logic [REG_W-1:0]   hi_o;
    logic [REG_W-1:0]   lo_o;
    logic               busy_o;

    modport master (
        output aluop_i, reg1_i, reg2_i, flush_i,
        input  stallreq_o, hi_o, lo_o, busy_o
    );

    modport slave (
        input  aluop_i, reg1_i, reg2_i, flush_i,
        output stallreq_o, hi_o, lo_o, busy_o
    );

endinterface

// File: rtl/muldiv_unit_div_core.sv
// -----------------------------------------------------------------------------
// div_core
//   Iterative radix-2 restoring divider, one quotient bit per cycle, 32 steps.
//   clk, rst       : clock, synchronous active-high reset (clears all state)
//   start_i        : latch operands and begin a division
//   signed_i       : treat operands as two's-complement
//   dividend_i     : dividend
//   divisor_i      : divisor (caller guarantees non-zero)
//   annul_i        : abandon the running division
//   done_o         : high during the final step; results are valid afterwards
//   quotient_o     : signed-corrected quotient
//   remainder_o    : signed-corrected remainder (sign of dividend)
// -----------------------------------------------------------------------------
module div_core
    import muldiv_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [REG_W-1:0] dividend_i,
    input  logic [REG_W-1:0] divisor_i,
    input  logic             annul_i,
    output logic             done_o,
    output logic [REG_W-1:0] quotient_o,
    output logic [REG_W-1:0] remainder_o
);

    logic [REG_W-1:0] r_quo;
    logic [REG_W-1:0] r_rem;
    logic [REG_W-1:0] r_dsr;
    logic [4:0]       r_cnt;
    logic             r_run;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [REG_W:0]   w_shift;
    logic             w_fit;
    logic [REG_W-1:0] w_sub;

    // Partial remainder shifted left with the next dividend bit brought in.
    // When it fits, the true difference is below the divisor, so the low
    // 32 bits of the subtraction are exact.
    assign w_shift = {r_rem, r_quo[REG_W-1]};
    assign w_fit   = (w_shift >= {1'b0, r_dsr});
    assign w_sub   = w_shift[REG_W-1:0] - r_dsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_dsr   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (annul_i) begin
            r_run <= 1'b0;
        end else if (start_i) begin
            r_quo   <= abs_if(dividend_i, signed_i);
            r_rem   <= '0;
            r_dsr   <= abs_if(divisor_i, signed_i);
            r_cnt   <= '0;
            r_run   <= 1'b1;
            r_neg_q <= signed_i & (dividend_i[REG_W-1] ^ divisor_i[REG_W-1]);
            r_neg_r <= signed_i & dividend_i[REG_W-1];
        end else if (r_run) begin
            r_quo <= {r_quo[REG_W-2:0], w_fit};
            r_rem <= w_fit ? w_sub : w_shift[REG_W-1:0];
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_run <= 1'b0;
            end
        end
    end

    assign done_o      = r_run && (r_cnt == 5'd31);
    assign quotient_o  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign remainder_o = r_neg_r ? (~r_rem + 1'b1) : r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   HI/LO multiply, multiply-accumulate and iterative divide unit.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (overrides flush and in-flight ops)
//   bus  : muldiv_unit_if.slave -- aluop_i, reg1_i, reg2_i, flush_i in;
//          stallreq_o, hi_o, lo_o, busy_o out.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DIV_RUN,
        ST_DIV_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [REG_W-1:0]   r_hi;
    logic [REG_W-1:0]   r_lo;
    logic [2*REG_W-1:0] r_prod;
    logic               r_mac_sub;
    logic               r_div_zero;

    logic               w_stall;
    logic               w_hi_we;
    logic               w_lo_we;
    logic [REG_W-1:0]   w_hi_d;
    logic [REG_W-1:0]   w_lo_d;
    logic               w_prod_we;
    logic               w_div_issue;
    logic               w_div_start;
    logic               w_div_by_zero;
    logic               w_mul_signed;
    logic               w_mac_sub_op;
    logic [REG_W-1:0]   w_mag1;
    logic [REG_W-1:0]   w_mag2;
    logic [2*REG_W-1:0] w_mag_prod;
    logic [2*REG_W-1:0] w_prod;
    logic [2*REG_W-1:0] w_mac_sum;
    logic               w_div_done;
    logic [REG_W-1:0]   w_div_quo;
    logic [REG_W-1:0]   w_div_rem;

    assign w_mul_signed = (bus.aluop_i == EXE_MULT_OP) ||
                          (bus.aluop_i == EXE_MADD_OP) ||
                          (bus.aluop_i == EXE_MSUB_OP);
    assign w_mac_sub_op = (bus.aluop_i == EXE_MSUB_OP) ||
                          (bus.aluop_i == EXE_MSUBU_OP);
    assign w_div_by_zero = (bus.reg2_i == '0);

    // Signed products are formed on magnitudes and negated when signs differ.
    assign w_mag1     = abs_if(bus.reg1_i, w_mul_signed);
    assign w_mag2     = abs_if(bus.reg2_i, w_mul_signed);
    assign w_mag_prod = {{REG_W{1'b0}}, w_mag1} * {{REG_W{1'b0}}, w_mag2};
    assign w_prod     = (w_mul_signed && (bus.reg1_i[REG_W-1] ^ bus.reg2_i[REG_W-1]))
                      ? (~w_mag_prod + 1'b1) : w_mag_prod;

    assign w_mac_sum = r_mac_sub ? ({r_hi, r_lo} - r_prod) : ({r_hi, r_lo} + r_prod);

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_hi_we      = 1'b0;
        w_lo_we      = 1'b0;
        w_hi_d       = r_hi;
        w_lo_d       = r_lo;
        w_prod_we    = 1'b0;
        w_div_issue  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                case (bus.aluop_i)
                    EXE_MULT_OP, EXE_MULTU_OP: begin
                        w_hi_we          = 1'b1;
                        w_lo_we          = 1'b1;
                        {w_hi_d, w_lo_d} = w_prod;
                    end
                    EXE_MTHI_OP: begin
                        w_hi_we = 1'b1;
                        w_hi_d  = bus.reg1_i;
                    end
                    EXE_MTLO_OP: begin
                        w_lo_we = 1'b1;
                        w_lo_d  = bus.reg1_i;
                    end
                    EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
                        w_stall      = 1'b1;
                        w_prod_we    = 1'b1;
                        w_state_next = ST_MAC;
                    end
                    EXE_DIV_OP, EXE_DIVU_OP: begin
                        w_stall      = 1'b1;
                        w_div_issue  = 1'b1;
                        w_state_next = w_div_by_zero ? ST_DIV_DONE : ST_DIV_RUN;
                    end
                    default: ;
                endcase
            end
            ST_MAC: begin
                w_hi_we          = 1'b1;
                w_lo_we          = 1'b1;
                {w_hi_d, w_lo_d} = w_mac_sum;
                w_state_next     = ST_IDLE;
            end
            ST_DIV_RUN: begin
                w_stall = 1'b1;
                if (w_div_done) begin
                    w_state_next = ST_DIV_DONE;
                end
            end
            ST_DIV_DONE: begin
                // The still-presented DIV op is consumed here, not reissued.
                w_hi_we      = 1'b1;
                w_lo_we      = 1'b1;
                w_hi_d       = r_div_zero ? '0 : w_div_rem;
                w_lo_d       = r_div_zero ? '0 : w_div_quo;
                w_state_next = ST_IDLE;
            end
        endcase
        // Abort suppresses every side effect of the current cycle.
        if (bus.flush_i || rst) begin
            w_state_next = ST_IDLE;
            w_stall      = 1'b0;
            w_hi_we      = 1'b0;
            w_lo_we      = 1'b0;
            w_prod_we    = 1'b0;
            w_div_issue  = 1'b0;
        end
    end

    assign w_div_start = w_div_issue && !w_div_by_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hi       <= '0;
            r_lo       <= '0;
            r_prod     <= '0;
            r_mac_sub  <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_hi_we) begin
                r_hi <= w_hi_d;
            end
            if (w_lo_we) begin
                r_lo <= w_lo_d;
            end
            if (w_prod_we) begin
                r_prod    <= w_prod;
                r_mac_sub <= w_mac_sub_op;
            end
            if (w_div_issue) begin
                r_div_zero <= w_div_by_zero;
            end
        end
    end

    div_core u_div_core (
        .clk         (clk),
        .rst         (rst),
        .start_i     (w_div_start),
        .signed_i    (bus.aluop_i == EXE_DIV_OP),
        .dividend_i  (bus.reg1_i),
        .divisor_i   (bus.reg2_i),
        .annul_i     (bus.flush_i),
        .done_o      (w_div_done),
        .quotient_o  (w_div_quo),
        .remainder_o (w_div_rem)
    );

    assign bus.stallreq_o = w_stall;
    assign bus.hi_o       = r_hi;
    assign bus.lo_o       = r_lo;
    assign bus.busy_o     = (r_state != ST_IDLE);

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have aluop_i  input  8  operation code from the decode stage (shared aluop codes).
REQ-004 SHALL have reg1_i  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-005 SHALL have reg2_i  input  32  rt operand (divisor / multiplier).
REQ-006 SHALL have flush_i  input  1  abort the in-flight operation, no HI/LO write.
REQ-007 SHALL have stallreq_o  output  1  pipeline hold request; upstream holds aluop_i/reg1_i/reg2_i while high.
REQ-008 SHALL have hi_o  output  32  registered HI.
REQ-009 SHALL have lo_o  output  32  registered LO.
REQ-010 SHALL have busy_o  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL use FSM states IDLE, MAC, DIV_RUN, DIV_DONE.
REQ-012 MULT/MULTU in IDLE SHALL write the 64-bit product {HI,LO} at the next edge; stallreq_o stays low; signed via two's-complement magnitudes, product negated if operand signs differ.
REQ-013 MTHI/MTLO in IDLE SHALL write reg1_i to HI/LO at the next edge; no stall.
REQ-014 MADD/MADDU/MSUB/MSUBU in IDLE SHALL assert stallreq_o combinationally, latch the 64-bit product, and go to MAC.
REQ-015 In MAC, stallreq_o SHALL be low; {HI,LO} +/- latched product (mod 2^64) SHALL be written at the edge ending MAC; next state IDLE.
REQ-016 DIV/DIVU in IDLE with reg2_i != 0 SHALL latch operands, assert stallreq_o, and enter DIV_RUN.
REQ-017 DIV_RUN SHALL perform one radix-2 restoring step per cycle for exactly 32 cycles with stallreq_o high, then enter DIV_DONE.
REQ-018 Total stall for a nonzero division SHALL be 33 cycles (issue cycle + 32).
REQ-019 In DIV_DONE, stallreq_o SHALL be low; HI=remainder and LO=quotient SHALL be written at the closing edge; next state IDLE; the re-presented DIV op SHALL NOT restart.
REQ-020 Signed DIV SHALL divide magnitudes; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-021 DIV/DIVU with reg2_i == 0 SHALL stall one cycle (DIV_DONE directly) and write HI=0, LO=0.
REQ-022 Operands SHALL be latched at issue; changes to reg1_i/reg2_i during MAC/DIV_RUN SHALL be ignored.
REQ-023 flush_i high in any state SHALL force IDLE at the next edge with HI/LO unchanged, including during DIV_DONE or MAC; stallreq_o SHALL be low while flush_i is high.
REQ-024 All other aluop codes SHALL leave state and HI/LO unchanged.
REQ-025 hi_o/lo_o SHALL reflect the registers only; there is no internal bypass.

Reset
REQ-026 On rst: state IDLE, HI=0, LO=0, divider registers cleared, stallreq_o=0, busy_o=0.
REQ-027 rst SHALL override flush_i and any in-flight operation, including mid-division.

Structure
REQ-028 Aluop codes and the 8-bit/32-bit bus widths SHALL come from the shared defines file; FSM state encodings SHALL be local constants.
REQ-029 The iterative divider SHALL be a sub-module div_core (start, signed flag, operands, done, quotient, remainder, annul); multiply/MAC logic SHALL stay in muldiv_unit.

Verification
REQ-030 MULT 0xFFFFFFFE x 0x00000003 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; stallreq_o never high.
REQ-031 DIVU 100 / 7 -> stallreq_o high 33 cycles; then HI=2, LO=14.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 DIV 5 / 0 -> stallreq_o high 1 cycle; HI=0, LO=0.
REQ-034 HI:LO=0:0x10, MADD 4 x 5 -> stallreq_o high 1 cycle; HI=0, LO=0x24; MSUBU of the same operands afterwards -> LO=0x10.
REQ-035 DIVU started, flush_i at DIV_RUN cycle 10 -> IDLE next edge, HI/LO unchanged, stallreq_o low; repeat with rst instead -> HI=LO=0.
